psum_mem_arbiter: RTL

//  Shares the single-port partial-sum memory between two requesters: port 0 = MAC loop controller
//  (latency-critical accumulate read/write-back), port 1 = output drain / host readout.

---
 rtl/psum_mem_arbiter_if.sv | 49 ++++
 rtl/psum_mem_arbiter.sv | 105 ++++++++++
 2 files changed

// File: rtl/psum_mem_arbiter_if.sv
// Request/response and memory-macro bundle for the partial-sum memory arbiter.
// slave = arbiter view, master = requesters plus memory macro view.
interface psum_mem_arbiter_if #(
   parameter int LOG2_OF_MEM_HEIGHT = 20,
   parameter int DATA_WIDTH         = 32
) ();
   logic                          p0_valid;
   logic                          p0_ready;
   logic                          p0_we;
   logic [LOG2_OF_MEM_HEIGHT-1:0] p0_addr;
   logic [DATA_WIDTH-1:0]         p0_wdata;
   logic                          p0_rsp_valid;
   logic [DATA_WIDTH-1:0]         p0_rsp_data;

   logic                          p1_valid;
   logic                          p1_ready;
   logic                          p1_we;
   logic [LOG2_OF_MEM_HEIGHT-1:0] p1_addr;
   logic [DATA_WIDTH-1:0]         p1_wdata;
   logic                          p1_rsp_valid;
   logic [DATA_WIDTH-1:0]         p1_rsp_data;

   logic                          mem_en;
   logic                          mem_we;
   logic [LOG2_OF_MEM_HEIGHT-1:0] mem_addr;
   logic [DATA_WIDTH-1:0]         mem_wdata;
   logic [DATA_WIDTH-1:0]         mem_rdata;
   logic [31:0]                   conflict_cnt;

   modport slave (
      input  p0_valid, p0_we, p0_addr, p0_wdata,
      output p0_ready, p0_rsp_valid, p0_rsp_data,
      input  p1_valid, p1_we, p1_addr, p1_wdata,
      output p1_ready, p1_rsp_valid, p1_rsp_data,
      output mem_en, mem_we, mem_addr, mem_wdata,
      input  mem_rdata,
      output conflict_cnt
   );

   modport master (
      output p0_valid, p0_we, p0_addr, p0_wdata,
      input  p0_ready, p0_rsp_valid, p0_rsp_data,
      output p1_valid, p1_we, p1_addr, p1_wdata,
      input  p1_ready, p1_rsp_valid, p1_rsp_data,
      input  mem_en, mem_we, mem_addr, mem_wdata,
      output mem_rdata,
      input  conflict_cnt
   );
endinterface

// File: rtl/psum_mem_arbiter.sv
// Single-port partial-sum memory arbiter: fixed priority to port 0 (MAC loop) with an
// anti-starvation counter forcing a port-1 grant, plus 1-cycle read-data return routing.
module psum_mem_arbiter #(
   parameter int LOG2_OF_MEM_HEIGHT = 20,
   parameter int DATA_WIDTH         = 32,
   parameter int STARVE_LIMIT       = 4
) (
   input logic                 clk,
   input logic                 arst_n_in,
   psum_mem_arbiter_if.slave   bus
);
   localparam int SW = (STARVE_LIMIT < 1) ? 1 : $clog2(STARVE_LIMIT + 1);
   localparam logic [SW-1:0] C_LIMIT = SW'(STARVE_LIMIT);

   logic                          w_force1;
   logic                          w_p0_ready;
   logic                          w_p1_ready;
   logic                          w_mem_en;
   logic                          w_mem_we;
   logic [LOG2_OF_MEM_HEIGHT-1:0] w_mem_addr;
   logic [DATA_WIDTH-1:0]         w_mem_wdata;
   logic                          w_p0_rsp_valid;
   logic                          w_p1_rsp_valid;

   logic [SW-1:0]                 r_starve_cnt;
   logic                          r_rd_pending;
   logic                          r_rd_owner;
   logic [31:0]                   r_conflict_cnt;

   // Grants are gated by reset so the macro never sees a strobe while reset is held.
   assign w_force1   = (r_starve_cnt == C_LIMIT);
   assign w_p1_ready = arst_n_in & bus.p1_valid & (~bus.p0_valid | w_force1);
   assign w_p0_ready = arst_n_in & bus.p0_valid & ~(bus.p1_valid & w_force1);
   assign w_mem_en   = w_p0_ready | w_p1_ready;

   // Memory command mux from whichever port holds the grant.
   always_comb begin
      w_mem_we    = 1'b0;
      w_mem_addr  = '0;
      w_mem_wdata = '0;
      if (w_p1_ready) begin
         w_mem_we    = bus.p1_we;
         w_mem_addr  = bus.p1_addr;
         w_mem_wdata = bus.p1_wdata;
      end else if (w_p0_ready) begin
         w_mem_we    = bus.p0_we;
         w_mem_addr  = bus.p0_addr;
         w_mem_wdata = bus.p0_wdata;
      end else begin
         w_mem_we    = 1'b0;
         w_mem_addr  = '0;
         w_mem_wdata = '0;
      end
   end

   // Anti-starvation counter: counts port-1 wait cycles, saturating at the limit.
   always_ff @(posedge clk or negedge arst_n_in) begin
      if (!arst_n_in) begin
         r_starve_cnt <= '0;
      end else if (!bus.p1_valid || w_p1_ready) begin
         r_starve_cnt <= '0;
      end else if (!w_force1) begin
         r_starve_cnt <= r_starve_cnt + SW'(1);
      end else begin
         r_starve_cnt <= r_starve_cnt;
      end
   end

   // Remember who issued the read so next cycle's macro data goes back to it.
   always_ff @(posedge clk or negedge arst_n_in) begin
      if (!arst_n_in) begin
         r_rd_pending <= 1'b0;
         r_rd_owner   <= 1'b0;
      end else begin
         r_rd_pending <= w_mem_en & ~w_mem_we;
         r_rd_owner   <= w_p1_ready;
      end
   end

   // Contention statistic, free-running and wrapping.
   always_ff @(posedge clk or negedge arst_n_in) begin
      if (!arst_n_in) begin
         r_conflict_cnt <= 32'd0;
      end else if (bus.p0_valid && bus.p1_valid) begin
         r_conflict_cnt <= r_conflict_cnt + 32'd1;
      end else begin
         r_conflict_cnt <= r_conflict_cnt;
      end
   end

   assign w_p0_rsp_valid = r_rd_pending & ~r_rd_owner;
   assign w_p1_rsp_valid = r_rd_pending & r_rd_owner;

   assign bus.p0_ready     = w_p0_ready;
   assign bus.p1_ready     = w_p1_ready;
   assign bus.mem_en       = w_mem_en;
   assign bus.mem_we       = w_mem_we;
   assign bus.mem_addr     = w_mem_addr;
   assign bus.mem_wdata    = w_mem_wdata;
   assign bus.p0_rsp_valid = w_p0_rsp_valid;
   assign bus.p1_rsp_valid = w_p1_rsp_valid;
   assign bus.p0_rsp_data  = w_p0_rsp_valid ? bus.mem_rdata : {DATA_WIDTH{1'b0}};
   assign bus.p1_rsp_data  = w_p1_rsp_valid ? bus.mem_rdata : {DATA_WIDTH{1'b0}};
   assign bus.conflict_cnt = r_conflict_cnt;
endmodule
